hazard_ctrl_mc: RTL

Parametrised hazard controller for the 5-stage RISC-V pipeline, superseding the forwarding-only hazard unit. It provides:
- M/W-to-E operand forwarding;
- load-use stall;
- taken-branch flush;
- a registered countdown FSM that freezes F/D/E and bubbles M while a multi-cycle execute op (mul/div) occupies E;
- saturating stall and flush event counters for performance debug.

---
 rtl/hazard_ctrl_mc.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/hazard_ctrl_mc.sv
// hazard_ctrl_mc: forwarding, load-use stall, branch flush, a multi-cycle
// execute countdown FSM and saturating stall/flush event counters for a
// 5-stage RISC-V pipeline. All stall/flush/forward outputs are combinational
// from inputs and FSM state; every output is held at 0 while rst is high.
module hazard_ctrl_mc #(
  parameter int REG_AW = 5,
  parameter int LAT_W  = 4,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] Rs1_D,
  input  logic [REG_AW-1:0] Rs2_D,
  input  logic [REG_AW-1:0] Rs1_E,
  input  logic [REG_AW-1:0] Rs2_E,
  input  logic [REG_AW-1:0] RD_E,
  input  logic [REG_AW-1:0] RD_M,
  input  logic [REG_AW-1:0] RD_W,
  input  logic              RegWriteM,
  input  logic              RegWriteW,
  input  logic              LoadE,
  input  logic              PCSrcE,
  input  logic              MCStartE,
  input  logic [LAT_W-1:0]  MCLatE,
  output logic [1:0]        ForwardAE,
  output logic [1:0]        ForwardBE,
  output logic              StallF,
  output logic              StallD,
  output logic              StallE,
  output logic              FlushD,
  output logic              FlushE,
  output logic              FlushM,
  output logic              MCBusy,
  output logic [CNT_W-1:0]  StallCnt,
  output logic [CNT_W-1:0]  FlushCnt
);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t            state_reg;
  logic [LAT_W-1:0]  cnt_reg;
  logic              busy_reg;
  logic [CNT_W-1:0]  stall_cnt_reg;
  logic [CNT_W-1:0]  flush_cnt_reg;

  logic       mc_stall;
  logic       lw_stall;
  logic [1:0] fwd_a;
  logic [1:0] fwd_b;
  logic       stall_fd;
  logic       flush_d;
  logic       flush_e;

  // Operand source select: the younger result in M wins over W; x0 never forwards.
  function automatic logic [1:0] fwd_sel(
    input logic [REG_AW-1:0] rs,
    input logic [REG_AW-1:0] rd_m,
    input logic [REG_AW-1:0] rd_w,
    input logic              we_m,
    input logic              we_w
  );
    if (we_m && (rd_m != '0) && (rd_m == rs))
      return 2'b10;
    else if (we_w && (rd_w != '0) && (rd_w == rs))
      return 2'b01;
    else
      return 2'b00;
  endfunction

  // Hazard detection and raw stall/flush equations.
  always_comb begin
    fwd_a    = fwd_sel(Rs1_E, RD_M, RD_W, RegWriteM, RegWriteW);
    fwd_b    = fwd_sel(Rs2_E, RD_M, RD_W, RegWriteM, RegWriteW);
    lw_stall = LoadE && (RD_E != '0) && ((RD_E == Rs1_D) || (RD_E == Rs2_D));
    if (state_reg == IDLE)
      mc_stall = MCStartE && (MCLatE > LAT_W'(1));
    else
      mc_stall = (cnt_reg != '0);
    // A taken branch must never be held, so it cancels the load-use stall;
    // while E holds a multi-cycle op, branch and load-use flushes are masked.
    stall_fd = mc_stall || (lw_stall && !PCSrcE);
    flush_d  = PCSrcE && !mc_stall;
    flush_e  = !mc_stall && (PCSrcE || lw_stall);
  end

  // Output gating: everything reads as zero while reset is held.
  always_comb begin
    ForwardAE = rst ? 2'b00 : fwd_a;
    ForwardBE = rst ? 2'b00 : fwd_b;
    StallF    = stall_fd && !rst;
    StallD    = stall_fd && !rst;
    StallE    = mc_stall && !rst;
    FlushD    = flush_d && !rst;
    FlushE    = flush_e && !rst;
    FlushM    = mc_stall && !rst;
    MCBusy    = busy_reg && !rst;
    StallCnt  = rst ? '0 : stall_cnt_reg;
    FlushCnt  = rst ? '0 : flush_cnt_reg;
  end

  // Multi-cycle countdown: the start cycle stalls, then cnt counts the
  // remaining stall cycles down to zero, so latency L stalls L-1 cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      busy_reg  <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (MCStartE && (MCLatE > LAT_W'(1))) begin
            cnt_reg   <= MCLatE - LAT_W'(2);
            state_reg <= BUSY;
            busy_reg  <= 1'b1;
          end
        end
        BUSY: begin
          if (cnt_reg != '0) begin
            cnt_reg <= cnt_reg - LAT_W'(1);
          end else begin
            state_reg <= IDLE;
            busy_reg  <= 1'b0;
          end
        end
        default: begin
          state_reg <= IDLE;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

  // Saturating performance counters for stall and flush cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_reg <= '0;
      flush_cnt_reg <= '0;
    end else begin
      if (stall_fd && (stall_cnt_reg != '1))
        stall_cnt_reg <= stall_cnt_reg + CNT_W'(1);
      if ((flush_d || flush_e || mc_stall) && (flush_cnt_reg != '1))
        flush_cnt_reg <= flush_cnt_reg + CNT_W'(1);
    end
  end

endmodule
